// File: rtl/pid_ahb_pkg.sv
// Shared definitions for the PID AHB-Lite slave.
//   - Word offsets (byte address [7:2]) of the register map.
//   - CTRL / STATUS bit positions.
//   - Sequencer state encoding.
package pid_ahb_pkg;

  // Word addresses, i.e. byte offset >> 2.
  localparam logic [5:0] AddrCtrl   = 6'h00;  // 0x00
  localparam logic [5:0] AddrStatus = 6'h01;  // 0x04
  localparam logic [5:0] AddrRuncnt = 6'h02;  // 0x08
  localparam logic [5:0] AddrCoeff  = 6'h04;  // 0x10 + 4k
  localparam logic [5:0] AddrDin    = 6'h10;  // 0x40 + 4c
  localparam logic [5:0] AddrDout   = 6'h20;  // 0x80 + 4c

  localparam int unsigned NumCoeff = 6;

  // CTRL bits
  localparam int unsigned CtrlInitn = 0;
  localparam int unsigned CtrlStart = 1;
  localparam int unsigned CtrlAuto  = 2;
  localparam int unsigned CtrlIrqEn = 3;

  // STATUS bits
  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatOverrun = 2;
  localparam int unsigned StatTimeout = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StCapt
  } seq_state_e;

endpackage

// File: rtl/pid_seq_fsm.sv
// Run sequencer for the PID core: IDLE -> LOAD -> RUN -> CAPT, with a watchdog
// in RUN and a free-running completed-run counter.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_req_i        software START strobe (data phase of a CTRL write)
//   auto_i             CTRL.AUTO, re-arm from CAPT
//   core_done_i        ap_done from the core
//   load_o             one-cycle snapshot strobe (LOAD)
//   capture_o          one-cycle DOUT capture strobe (CAPT)
//   core_start_o       ap_start (RUN)
//   busy_o             sequencer not idle
//   timeout_set_o      watchdog expired this cycle
//   done_set_o         run completed this cycle
//   overrun_set_o      START requested while busy
//   runcnt_o           completed-run counter, wraps
module pid_seq_fsm
  import pid_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_req_i,
  input  logic        auto_i,
  input  logic        core_done_i,
  output logic        load_o,
  output logic        capture_o,
  output logic        core_start_o,
  output logic        busy_o,
  output logic        timeout_set_o,
  output logic        done_set_o,
  output logic        overrun_set_o,
  output logic [31:0] runcnt_o
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  seq_state_e     state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [31:0]    runcnt_q, runcnt_d;

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    runcnt_d      = runcnt_q;
    load_o        = 1'b0;
    capture_o     = 1'b0;
    core_start_o  = 1'b0;
    timeout_set_o = 1'b0;
    done_set_o    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_req_i) state_d = StLoad;
      end
      StLoad: begin
        load_o  = 1'b1;
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        core_start_o = 1'b1;
        // A done in the last watchdog cycle still counts as a completion.
        if (core_done_i) begin
          state_d = StCapt;
        end else if (wd_q == WdLast) begin
          timeout_set_o = 1'b1;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCapt: begin
        capture_o  = 1'b1;
        done_set_o = 1'b1;
        runcnt_d   = runcnt_q + 32'd1;
        state_d    = auto_i ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  // START during CAPT is also rejected: the run in flight owns the core.
  assign overrun_set_o = start_req_i & busy_o;
  assign runcnt_o      = runcnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wd_q     <= '0;
      runcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      runcnt_q <= runcnt_d;
    end
  end

endmodule

// File: rtl/pid_ahb_slave.sv
// AHB-Lite slave fronting a multi-channel PID core. Holds CTRL/STATUS,
// coefficient and input registers, snapshots them into the core on START,
// and captures the core outputs into read-back DOUT registers.
// Optional feature: define PID_AHB_IRQ_EN to add the irq output and CTRL.IRQ_EN.
// Ports:
//   HCLK, HRESETn                 clock, synchronous active-low reset
//   HSEL..HWDATA, HRDATA          AHB-Lite slave port (zero wait states)
//   HREADYOUT, HRESP              tied to ready / OKAY
//   core_start, core_done         ap_start / ap_done handshake
//   core_initn                    InitN snapshot
//   core_coeff, core_din          snapshot coefficients / inputs
//   core_dout                     core outputs, captured on completion
//   irq                           (PID_AHB_IRQ_EN only) IRQ_EN & (DONE | TIMEOUT)
module pid_ahb_slave
  import pid_ahb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned COEFF_W = 25,
  parameter int unsigned DIN_W   = 25,
  parameter int unsigned DOUT_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic                      HREADY,
  input  logic                      HWRITE,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic [31:0]               HADDR,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic                      core_start,
  input  logic                      core_done,
  output logic                      core_initn,
  output logic [6*COEFF_W-1:0]      core_coeff,
  output logic [NUM_CH*DIN_W-1:0]   core_din,
  input  logic [NUM_CH*DOUT_W-1:0]  core_dout
`ifdef PID_AHB_IRQ_EN
  ,
  output logic                      irq
`endif
);

  // Bus address/data phase
  logic       act_q, wr_q;
  logic [5:0] addr_q;
  logic       addr_ph, wr_en, ctrl_we, stat_we, start_req, start_go;

  // Register file
  logic               initn_q, auto_q, irq_en;
  logic [COEFF_W-1:0] coeff_q [NumCoeff];
  logic [DIN_W-1:0]   din_q   [NUM_CH];
  logic [DOUT_W-1:0]  dout_q  [NUM_CH];
  logic               done_q, done_d, overrun_q, overrun_d, timeout_q, timeout_d;

  // Core snapshot
  logic [6*COEFF_W-1:0]    coeff_snap_q;
  logic [NUM_CH*DIN_W-1:0] din_snap_q;
  logic                    initn_snap_q;

  // Sequencer
  logic        load, capture, busy, timeout_set, done_set, overrun_set;
  logic [31:0] runcnt;
  logic [3:0]  status_w;
  logic [31:0] rdata;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:8], HADDR[1:0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign addr_ph   = HSEL & HREADY & HTRANS[1];
  assign wr_en     = act_q & wr_q;
  assign ctrl_we   = wr_en & (addr_q == AddrCtrl);
  assign stat_we   = wr_en & (addr_q == AddrStatus);
  assign start_req = ctrl_we & HWDATA[CtrlStart];
  assign start_go  = start_req & ~busy;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      act_q <= addr_ph;
      if (addr_ph) begin
        wr_q   <= HWRITE;
        addr_q <= HADDR[7:2];
      end
    end
  end

  pid_seq_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_seq (
    .clk_i         (HCLK),
    .rst_ni        (HRESETn),
    .start_req_i   (start_req),
    .auto_i        (auto_q),
    .core_done_i   (core_done),
    .load_o        (load),
    .capture_o     (capture),
    .core_start_o  (core_start),
    .busy_o        (busy),
    .timeout_set_o (timeout_set),
    .done_set_o    (done_set),
    .overrun_set_o (overrun_set),
    .runcnt_o      (runcnt)
  );

  // Writes land immediately, even while busy; the core only sees them at LOAD.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      initn_q <= 1'b0;
      auto_q  <= 1'b0;
      coeff_q <= '{default: '0};
      din_q   <= '{default: '0};
    end else begin
      if (ctrl_we) begin
        initn_q <= HWDATA[CtrlInitn];
        auto_q  <= HWDATA[CtrlAuto];
      end
      for (int k = 0; k < NumCoeff; k++) begin
        if (wr_en && (addr_q == AddrCoeff + 6'(k))) coeff_q[k] <= HWDATA[COEFF_W-1:0];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en && (addr_q == AddrDin + 6'(c))) din_q[c] <= HWDATA[DIN_W-1:0];
      end
    end
  end

`ifdef PID_AHB_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_we) irq_en_q <= HWDATA[CtrlIrqEn];
      irq_q <= irq_en_q & (done_q | timeout_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  // W1C and START-clear first, hardware set last so a same-cycle set wins.
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (start_go) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    if (stat_we) begin
      if (HWDATA[StatDone])    done_d    = 1'b0;
      if (HWDATA[StatOverrun]) overrun_d = 1'b0;
      if (HWDATA[StatTimeout]) timeout_d = 1'b0;
    end
    if (done_set)    done_d    = 1'b1;
    if (timeout_set) timeout_d = 1'b1;
    if (overrun_set) overrun_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      coeff_snap_q <= '0;
      din_snap_q   <= '0;
      initn_snap_q <= 1'b0;
      dout_q       <= '{default: '0};
    end else begin
      if (load) begin
        initn_snap_q <= initn_q;
        for (int k = 0; k < NumCoeff; k++) coeff_snap_q[k*COEFF_W +: COEFF_W] <= coeff_q[k];
        for (int c = 0; c < NUM_CH; c++) din_snap_q[c*DIN_W +: DIN_W] <= din_q[c];
      end
      if (capture) begin
        for (int c = 0; c < NUM_CH; c++) dout_q[c] <= core_dout[c*DOUT_W +: DOUT_W];
      end
    end
  end

  assign core_coeff = coeff_snap_q;
  assign core_din   = din_snap_q;
  assign core_initn = initn_snap_q;

  always_comb begin
    status_w              = '0;
    status_w[StatBusy]    = busy;
    status_w[StatDone]    = done_q;
    status_w[StatOverrun] = overrun_q;
    status_w[StatTimeout] = timeout_q;
  end

  always_comb begin
    rdata = '0;
    if (act_q && !wr_q) begin
      if (addr_q == AddrCtrl) begin
        rdata[CtrlInitn] = initn_q;
        rdata[CtrlAuto]  = auto_q;
        rdata[CtrlIrqEn] = irq_en;
      end
      if (addr_q == AddrStatus) rdata = {28'd0, status_w};
      if (addr_q == AddrRuncnt) rdata = runcnt;
      for (int k = 0; k < NumCoeff; k++) begin
        if (addr_q == AddrCoeff + 6'(k)) rdata = 32'(coeff_q[k]);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr_q == AddrDin + 6'(c))  rdata = 32'(din_q[c]);
        if (addr_q == AddrDout + 6'(c)) rdata = 32'(dout_q[c]);
      end
    end
  end

  assign HRDATA = rdata;

endmodule

// File: tb/tb_pid_ahb_slave.sv
// Directed bench for pid_ahb_slave with a small PID core model that raises
// core_done five cycles after core_start rises and presents dout = {0x22, 0x11}.
module tb_pid_ahb_slave;

  localparam int unsigned NumCh  = 2;
  localparam int unsigned CoeffW = 25;
  localparam int unsigned DinW   = 25;
  localparam int unsigned DoutW  = 8;
  localparam int unsigned Tmo    = 16;

  logic                     HCLK = 1'b0;
  logic                     HRESETn = 1'b0;
  logic                     HSEL = 1'b0;
  logic                     HREADY = 1'b1;
  logic                     HWRITE = 1'b0;
  logic [1:0]               HTRANS = 2'b00;
  logic [2:0]               HSIZE = 3'b010;
  logic [31:0]              HADDR = '0;
  logic [31:0]              HWDATA = '0;
  logic [31:0]              HRDATA;
  logic                     HREADYOUT, HRESP;
  logic                     core_start, core_done, core_initn;
  logic [6*CoeffW-1:0]      core_coeff;
  logic [NumCh*DinW-1:0]    core_din;
  logic [NumCh*DoutW-1:0]   core_dout;
`ifdef PID_AHB_IRQ_EN
  logic                     irq;
`endif

  pid_ahb_slave #(
    .NUM_CH  (NumCh),
    .COEFF_W (CoeffW),
    .DIN_W   (DinW),
    .DOUT_W  (DoutW),
    .TIMEOUT (Tmo)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HWRITE     (HWRITE),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .core_start (core_start),
    .core_done  (core_done),
    .core_initn (core_initn),
    .core_coeff (core_coeff),
    .core_din   (core_din),
    .core_dout  (core_dout)
`ifdef PID_AHB_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Core model
  bit          model_en = 1'b1;
  int unsigned mcnt = 0;
  always @(posedge HCLK) begin
    if (core_start !== 1'b1) mcnt <= 0;
    else                     mcnt <= mcnt + 1;
    core_done <= model_en && (core_start === 1'b1) && (mcnt == 4);
  end
  assign core_dout = 16'h2211;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    cycles(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    cycles(1);
  endtask

  task automatic check_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    cycles(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    v = HRDATA;
    check_eq(tag, v, exp);
    cycles(1);
  endtask

  // Returns in the first cycle core_done is high (or after the bound).
  task automatic wait_done(input string tag);
    int i = 0;
    while (core_done !== 1'b1 && i < 200) begin
      cycles(1);
      i++;
    end
    check_eq(tag, 32'(core_done), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    cycles(3);
    HRESETn = 1'b1;

    // Reset values
    check_eq("rst_core_start", 32'(core_start), 32'h0);
    check_eq("rst_core_initn", 32'(core_initn), 32'h0);
    check_eq("rst_hrdata", HRDATA, 32'h0);
    check_rd("rst_ctrl", 8'h00, 32'h0);
    check_rd("rst_status", 8'h04, 32'h0);
    check_rd("rst_runcnt", 8'h08, 32'h0);
    check_rd("rst_coeff0", 8'h10, 32'h0);
    check_rd("rst_din0", 8'h40, 32'h0);
    check_rd("rst_dout0", 8'h80, 32'h0);
    check_rd("rst_dout1", 8'h84, 32'h0);

    // Register file, width masking, unmapped
    ahb_write(8'h24, 32'hFFFF_FFFF);
    check_rd("coeff5_mask", 8'h24, 32'h01FF_FFFF);
    for (int k = 0; k < 6; k++) ahb_write(8'h10 + 8'(4 * k), 32'(k + 1));
    ahb_write(8'h40, 32'h100);
    ahb_write(8'h44, 32'h200);
    check_rd("coeff5", 8'h24, 32'h6);
    check_rd("din1", 8'h44, 32'h200);
    ahb_write(8'h0C, 32'hDEAD_BEEF);
    check_rd("unmapped_0c", 8'h0C, 32'h0);
    ahb_write(8'h84, 32'h55);
    check_rd("dout1_ro", 8'h84, 32'h0);

    // Single run: START data phase N, LOAD N+1, core_start N+2
    ahb_write(8'h00, 32'h3);
    check_eq("lat_load_nostart", 32'(core_start), 32'h0);
    cycles(1);
    check_eq("lat_run_start", 32'(core_start), 32'h1);
    check_eq("snap_coeff0", 32'(core_coeff[0 +: CoeffW]), 32'h1);
    check_eq("snap_coeff5", 32'(core_coeff[5*CoeffW +: CoeffW]), 32'h6);
    check_eq("snap_din1", 32'(core_din[DinW +: DinW]), 32'h200);
    check_eq("snap_initn", 32'(core_initn), 32'h1);
    check_rd("ctrl_start_reads0", 8'h00, 32'h1);
    check_rd("status_busy", 8'h04, 32'h1);
    wait_done("run1_done");
    check_eq("run1_start_at_done", 32'(core_start), 32'h1);
    cycles(1);
    check_eq("run1_capt_start_low", 32'(core_start), 32'h0);
    check_rd("run1_dout0", 8'h80, 32'h11);
    check_rd("run1_dout1", 8'h84, 32'h22);
    check_rd("run1_status", 8'h04, 32'h2);
    check_rd("run1_runcnt", 8'h08, 32'h1);

    // Watchdog
    model_en = 1'b0;
    ahb_write(8'h00, 32'h3);
    n = 0;
    while (core_start !== 1'b1 && n < 50) begin
      cycles(1);
      n++;
    end
    check_eq("wd_start_rise", 32'(core_start), 32'h1);
    n = 0;
    while (core_start === 1'b1 && n < 100) begin
      cycles(1);
      n++;
    end
    check_eq("wd_run_len", 32'(n), 32'(Tmo));
    check_rd("wd_status", 8'h04, 32'h8);
    check_rd("wd_dout0_kept", 8'h80, 32'h11);
    check_rd("wd_runcnt_kept", 8'h08, 32'h1);

    // OVERRUN: second START lands while running
    model_en = 1'b1;
    ahb_write(8'h00, 32'h3);
    ahb_write(8'h00, 32'h3);
    wait_done("ovr_done");
    cycles(12);
    check_eq("ovr_no_restart", 32'(core_start), 32'h0);
    check_rd("ovr_status", 8'h04, 32'h6);
    check_rd("ovr_runcnt", 8'h08, 32'h2);
    ahb_write(8'h04, 32'h4);
    check_rd("ovr_w1c", 8'h04, 32'h2);
    ahb_write(8'h04, 32'h2);
    check_rd("done_w1c", 8'h04, 32'h0);

    // AUTO mode
    ahb_write(8'h00, 32'h7);
    wait_done("auto_done1");
    cycles(2);
    check_rd("auto_runcnt3", 8'h08, 32'h3);
    ahb_write(8'h40, 32'h333);
    check_eq("auto_din_old", 32'(core_din[0 +: DinW]), 32'h100);
    wait_done("auto_done2");
    cycles(3);
    check_eq("auto_din_new", 32'(core_din[0 +: DinW]), 32'h333);
    ahb_write(8'h00, 32'h1);
    cycles(30);
    check_eq("auto_stopped", 32'(core_start), 32'h0);
    check_rd("auto_runcnt5", 8'h08, 32'h5);
    check_rd("auto_status", 8'h04, 32'h2);

    // IRQ_EN bit and interrupt
    ahb_write(8'h00, 32'h9);
`ifdef PID_AHB_IRQ_EN
    check_rd("ctrl_irq_en", 8'h00, 32'h9);
    ahb_write(8'h00, 32'hB);
    wait_done("irq_done");
    cycles(2);
    check_eq("irq_low_at_done", 32'(irq), 32'h0);
    cycles(1);
    check_eq("irq_rise", 32'(irq), 32'h1);
    ahb_write(8'h04, 32'h2);
    check_eq("irq_still_high", 32'(irq), 32'h1);
    cycles(1);
    check_eq("irq_fall", 32'(irq), 32'h0);
`else
    check_rd("ctrl_irq_en_absent", 8'h00, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
